// File: rtl/gray_conv_arbiter.sv
// Two-requester binary-to-Gray converter with a shared output port.
// Define GRAY_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module gray_conv_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       conv_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cap_bin;
  logic             cap_id;
  logic             pick1;
  logic             grant;

`ifndef GRAY_ARB_FIXED_PRIO_EN
  logic             rr_last;
`endif

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  // Grants are combinational in IDLE and forced low while reset is held
  always_comb begin
    pick1 = 1'b0;
`ifdef GRAY_ARB_FIXED_PRIO_EN
    pick1 = req1 & ~req0;
`else
    pick1 = req1 & (~req0 | ~rr_last);
`endif
    gnt0  = rst_n & (state == IDLE) & req0 & ~pick1;
    gnt1  = rst_n & (state == IDLE) & pick1;
    grant = gnt0 | gnt1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_bin    <= '0;
      cap_id     <= 1'b0;
      out_valid  <= 1'b0;
      out_gray   <= '0;
      out_id     <= 1'b0;
      conv_count <= '0;
`ifndef GRAY_ARB_FIXED_PRIO_EN
      rr_last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            cap_bin <= gnt1 ? bin1 : bin0;
            cap_id  <= gnt1;
`ifndef GRAY_ARB_FIXED_PRIO_EN
            rr_last <= gnt1;
`endif
            state   <= CONV;
          end
        end
        CONV: begin
          out_gray  <= to_gray(cap_bin);
          out_id    <= cap_id;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          // Result held until the consumer takes it
          if (out_ready) begin
            out_valid  <= 1'b0;
            conv_count <= conv_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_gray_conv_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, out_ready;
  logic [W-1:0] bin0, bin1;
  logic         gnt0, gnt1, out_valid, out_id, busy;
  logic [W-1:0] out_gray;
  logic [7:0]   conv_count;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = waiting, 1 = converting, 2 = presenting
  int           ph;
  int           m_last;
  int           last_w;
  logic [7:0]   m_count;
  logic [W-1:0] m_gray, m_bin;
  logic         m_id, m_cid;

  logic [16:0]  act;

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .bin0(bin0), .gnt0(gnt0),
    .req1(req1), .bin1(bin1), .gnt1(gnt1),
    .out_valid(out_valid), .out_gray(out_gray), .out_id(out_id),
    .out_ready(out_ready), .busy(busy), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  assign act = {gnt0, gnt1, busy, out_valid, out_id, out_gray, conv_count};

  function automatic int m_winner();
    if (ph != 0 || !rst_n) return -1;
    if (req0 && req1) begin
`ifdef GRAY_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 1) ? 0 : 1;
`endif
    end
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  function automatic logic [16:0] m_expect();
    int w;
    w = m_winner();
    return {w == 0, w == 1, ph != 0, ph == 2, m_id, m_gray, m_count};
  endfunction

  task automatic m_reset();
    ph = 0; m_last = 1; m_count = 8'd0; m_gray = '0; m_id = 1'b0;
    m_bin = '0; m_cid = 1'b0;
  endtask

  // Advance the model by one clock edge, then move to just after that edge
  task automatic adv();
    last_w = m_winner();
    case (ph)
      0: if (last_w >= 0) begin
           m_bin  = (last_w == 1) ? bin1 : bin0;
           m_cid  = (last_w == 1);
           m_last = last_w;
           ph     = 1;
         end
      1: begin
           m_gray = m_bin ^ (m_bin >> 1);
           m_id   = m_cid;
           ph     = 2;
         end
      default: if (out_ready) begin
           m_count = m_count + 8'd1;
           ph      = 0;
         end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; bin0 = 4'hA; bin1 = 4'h5; out_ready = 1'b0;
    m_reset();
    #3;
    total++;
    if (act !== 17'h0) begin bad++; $display("FAIL reset_async got=%h exp=%h", act, 17'h0); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (act !== 17'h0) begin bad++; $display("FAIL reset_held got=%h exp=%h", act, 17'h0); end
    @(posedge clk); #1;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    total++;
    if (act !== m_expect()) begin bad++; $display("FAIL reset_release got=%h exp=%h", act, m_expect()); end
    adv();
  endtask

  task automatic test_single();
    req0 = 1'b1; bin0 = 4'b1011; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL single_c%0d got=%h exp=%h", c, act, m_expect()); end
      if (c == 0) begin
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b exp=10", {gnt0, gnt1}); end
      end
      if (c == 2) begin
        total++;
        if ({out_valid, out_gray, out_id} !== {1'b1, 4'b1110, 1'b0}) begin
          bad++; $display("FAIL single_result got=%b exp=%b", {out_valid, out_gray, out_id}, {1'b1, 4'b1110, 1'b0});
        end
      end
      if (c == 3) begin
        total++;
        if (conv_count !== 8'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", conv_count); end
      end
      adv();
      if (last_w == 0) req0 = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int prev;
    prev = -1;
    req0 = 1'b1; req1 = 1'b1; bin0 = 4'b0101; bin1 = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL rr_c%0d got=%h exp=%h", c, act, m_expect()); end
      if (out_valid) begin
        total++;
        if (out_gray !== (out_id ? 4'b1000 : 4'b0111)) begin
          bad++; $display("FAIL rr_gray got=%b id=%0d", out_gray, out_id);
        end
      end
      if (gnt0 || gnt1) begin
        total++;
`ifdef GRAY_ARB_FIXED_PRIO_EN
        if (gnt1) begin bad++; $display("FAIL rr_fixed got=gnt1 exp=gnt0"); end
`else
        if (prev >= 0 && int'(gnt1) == prev) begin
          bad++; $display("FAIL rr_alternate got=%0d exp=%0d", int'(gnt1), 1 - prev);
        end
`endif
        prev = int'(gnt1);
      end
      adv();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 4 && ph != 0; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL rr_drain got=%h exp=%h", act, m_expect()); end
      adv();
    end
  endtask

  task automatic test_backpressure();
    req0 = 1'b0; req1 = 1'b1; bin1 = 4'b0000; out_ready = 1'b0;
    for (int c = 0; c < 6 && ph != 2; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL bp_start got=%h exp=%h", act, m_expect()); end
      adv();
      if (last_w == 1) req1 = 1'b0;
    end
    req0 = 1'b1; bin0 = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_gray, out_id, gnt0, gnt1} !== {1'b1, 4'b0000, 1'b1, 2'b00}) begin
        bad++; $display("FAIL bp_hold_k%0d got=%b exp=%b", k, {out_valid, out_gray, out_id, gnt0, gnt1}, {1'b1, 4'b0000, 1'b1, 2'b00});
      end
      adv();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL bp_c%0d got=%h exp=%h", c, act, m_expect()); end
      adv();
      if (last_w == 0) req0 = 1'b0;
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] v;
    out_ready = 1'b1; req1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = W'(i);
      req0 = 1'b1; bin0 = v;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total++;
        if (act !== m_expect()) begin bad++; $display("FAIL sweep_%0d got=%h exp=%h", i, act, m_expect()); end
        if (c == 2) begin
          total++;
          if (out_valid !== 1'b1 || out_gray !== (v ^ (v >> 1))) begin
            bad++; $display("FAIL sweep_gray_%0d got=%b exp=%b", i, out_gray, v ^ (v >> 1));
          end
        end
        adv();
        if (last_w == 0) req0 = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; bin0 = W'($urandom); end
      if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; bin1 = W'($urandom); end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL random_c%0d got=%h exp=%h", c, act, m_expect()); end
      adv();
      if (last_w == 0) req0 = 1'b0;
      if (last_w == 1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4 && ph != 0; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL random_drain got=%h exp=%h", act, m_expect()); end
      adv();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] start, prev;
    bit         wrapped;
    start = m_count; wrapped = 1'b0;
    req0 = 1'b1; req1 = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 768; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL wrap_c%0d got=%h exp=%h", c, act, m_expect()); end
      prev = m_count;
      adv();
      if (prev == 8'd255 && m_count == 8'd0) wrapped = 1'b1;
    end
    req0 = 1'b0;
    @(negedge clk);
    total++;
    if (!wrapped || conv_count !== start) begin
      bad++; $display("FAIL wrap_final got=%0d exp=%0d wrapped=%0d", conv_count, start, wrapped);
    end
    adv();
  endtask

  task automatic test_async_reset();
    req0 = 1'b0; req1 = 1'b1; bin1 = 4'b1001; out_ready = 1'b0;
    for (int c = 0; c < 6 && ph != 2; c++) begin
      @(negedge clk);
      total++;
      if (act !== m_expect()) begin bad++; $display("FAIL areset_start got=%h exp=%h", act, m_expect()); end
      adv();
      if (last_w == 1) req1 = 1'b0;
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_reach_out got=%b exp=1", out_valid); end
    req0 = 1'b1; req1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (act !== 17'h0) begin bad++; $display("FAIL areset_drop got=%h exp=%h", act, 17'h0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    total++;
    if ({gnt0, gnt1} !== 2'b10 || act !== m_expect()) begin
      bad++; $display("FAIL areset_first_gnt got=%h exp=%h", act, m_expect());
    end
    adv();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sweep();
    test_random();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
